uart_cmd_rx: RTL and testbench

Serial remote-control front end for the frog game. It receives 8N1 UART frames from a host PC on the Go Board RX pin and decodes ASCII command bytes. Each command becomes a held move or reset level on a 4-bit bus with the same bit order as the debounced switch bus, OR-ed into it ahead of `frog_display`. It is the inbound counterpart to the switch/debounce input path: a second, remote source of the same button events.

---
 rtl/frog_uart_pkg.sv | 58 +++++
 rtl/uart_rx_core.sv | 131 +++++++++++++
 rtl/uart_cmd_rx.sv | 86 ++++++++
 tb/tb_uart_cmd_rx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/frog_uart_pkg.sv
// -----------------------------------------------------------------------------
// frog_uart_pkg
// Shared types and constants for the frog game's UART remote-control path.
//   rx_state_t     : bit-level receiver FSM states
//   CMD_*          : ASCII command bytes (lower and upper case)
//   MOVE_*         : bit positions on the 4-bit move bus {right, up, down, left},
//                    identical to the debounced switch bus ordering
//   cmd_decode()   : maps a received byte to a move pattern plus a hit flag
// Optional build macro affecting users of this package: UART_CMD_RX_PARITY_EN
// -----------------------------------------------------------------------------
package frog_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam logic [7:0] CMD_LEFT_LC  = 8'h61;  // 'a'
  localparam logic [7:0] CMD_LEFT_UC  = 8'h41;  // 'A'
  localparam logic [7:0] CMD_DOWN_LC  = 8'h73;  // 's'
  localparam logic [7:0] CMD_DOWN_UC  = 8'h53;  // 'S'
  localparam logic [7:0] CMD_UP_LC    = 8'h77;  // 'w'
  localparam logic [7:0] CMD_UP_UC    = 8'h57;  // 'W'
  localparam logic [7:0] CMD_RIGHT_LC = 8'h64;  // 'd'
  localparam logic [7:0] CMD_RIGHT_UC = 8'h44;  // 'D'
  localparam logic [7:0] CMD_RESET_LC = 8'h72;  // 'r'
  localparam logic [7:0] CMD_RESET_UC = 8'h52;  // 'R'

  localparam int MOVE_LEFT  = 0;
  localparam int MOVE_DOWN  = 1;
  localparam int MOVE_UP    = 2;
  localparam int MOVE_RIGHT = 3;

  typedef struct packed {
    logic       hit;
    logic [3:0] move;
  } cmd_t;

  function automatic cmd_t cmd_decode(input logic [7:0] b);
    cmd_t c;
    c.hit  = 1'b1;
    c.move = 4'b0000;
    case (b)
      CMD_LEFT_LC,  CMD_LEFT_UC:  c.move[MOVE_LEFT]  = 1'b1;
      CMD_DOWN_LC,  CMD_DOWN_UC:  c.move[MOVE_DOWN]  = 1'b1;
      CMD_UP_LC,    CMD_UP_UC:    c.move[MOVE_UP]    = 1'b1;
      CMD_RIGHT_LC, CMD_RIGHT_UC: c.move[MOVE_RIGHT] = 1'b1;
      // All four buttons together is the game's reset combination.
      CMD_RESET_LC, CMD_RESET_UC: c.move = 4'b1111;
      default:                    c.hit  = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
// UART receiver: 2-FF synchronizer, bit-level FSM and byte/valid/error outputs.
// Frames are 8N1, or 8E1 when UART_CMD_RX_PARITY_EN is defined.
// Ports:
//   i_Clk        : system clock
//   i_Rst_L      : asynchronous active-low reset
//   i_Rx_Serial  : UART line, idle high, asynchronous to i_Clk
//   o_Rx_Byte    : last correctly framed byte (registered on the stop sample)
//   o_Rx_Valid   : one-cycle pulse when o_Rx_Byte updates
//   o_Frame_Err  : one-cycle pulse on bad stop bit (or bad parity)
// -----------------------------------------------------------------------------
module uart_rx_core
  import frog_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Rx_Serial,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Valid,
  output logic       o_Frame_Err
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);

  logic          sync1_reg, sync2_reg;
  logic [1:0]    warm_reg;
  logic          prev_reg;
  rx_state_t     state_reg, state_next;
  logic [CW-1:0] cnt_reg;
  logic [2:0]    bit_reg;
  logic [7:0]    shift_reg;
  logic [7:0]    byte_reg;
  logic          valid_reg, err_reg;
  logic          fall, cnt_clr, sample_data, stop_tick, par_ok;
`ifdef UART_CMD_RX_PARITY_EN
  logic          par_reg;
  logic          sample_par;
`endif

  // A start needs a real high-to-low transition. prev_reg only tracks the line
  // once the synchronizer holds genuine samples, so a line that is already low
  // when reset releases cannot be mistaken for a start bit.
  assign fall = prev_reg & ~sync2_reg;

  // State register
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (fall) state_next = START;
      START:  if (cnt_reg == HALF_CNT) state_next = sync2_reg ? IDLE : DATA;
      DATA:   if (cnt_reg == FULL_CNT && bit_reg == 3'd7) begin
`ifdef UART_CMD_RX_PARITY_EN
                state_next = PARITY;
`else
                state_next = STOP;
`endif
              end
      PARITY: if (cnt_reg == FULL_CNT) state_next = STOP;
      STOP:   if (cnt_reg == FULL_CNT) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / strobe logic
  always_comb begin
    sample_data = (state_reg == DATA) && (cnt_reg == FULL_CNT);
    stop_tick   = (state_reg == STOP) && (cnt_reg == FULL_CNT);
    cnt_clr     = (state_reg != state_next) || sample_data;
`ifdef UART_CMD_RX_PARITY_EN
    sample_par  = (state_reg == PARITY) && (cnt_reg == FULL_CNT);
    par_ok      = (par_reg == ^shift_reg);
`else
    par_ok      = 1'b1;
`endif
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      warm_reg  <= 2'b00;
      prev_reg  <= 1'b0;
      cnt_reg   <= '0;
      bit_reg   <= 3'd0;
      shift_reg <= 8'h00;
      byte_reg  <= 8'h00;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
`ifdef UART_CMD_RX_PARITY_EN
      par_reg   <= 1'b0;
`endif
    end else begin
      sync1_reg <= i_Rx_Serial;
      sync2_reg <= sync1_reg;
      warm_reg  <= {warm_reg[0], 1'b1};
      prev_reg  <= warm_reg[1] & sync2_reg;

      if (cnt_clr)                  cnt_reg <= '0;
      else if (cnt_reg != FULL_CNT) cnt_reg <= cnt_reg + 1'b1;

      if (state_reg != DATA)                   bit_reg <= 3'd0;
      else if (sample_data && bit_reg != 3'd7) bit_reg <= bit_reg + 3'd1;

      // LSB arrives first, so shift in from the top.
      if (sample_data) shift_reg <= {sync2_reg, shift_reg[7:1]};
`ifdef UART_CMD_RX_PARITY_EN
      if (sample_par)  par_reg <= sync2_reg;
`endif

      valid_reg <= stop_tick & sync2_reg & par_ok;
      err_reg   <= stop_tick & ~(sync2_reg & par_ok);
      if (stop_tick && sync2_reg && par_ok) byte_reg <= shift_reg;
    end
  end

  assign o_Rx_Byte   = byte_reg;
  assign o_Rx_Valid  = valid_reg;
  assign o_Frame_Err = err_reg;

endmodule

// File: rtl/uart_cmd_rx.sv
// -----------------------------------------------------------------------------
// uart_cmd_rx
// Remote-control front end for the frog game: receives UART command bytes and
// turns recognized ASCII commands into a held level on the 4-bit move bus,
// meant to be OR-ed with the debounced switch bus.
// Build macro: UART_CMD_RX_PARITY_EN (defined = 8E1 frames, undefined = 8N1).
// Ports:
//   i_Clk        : system clock
//   i_Rst_L      : asynchronous active-low reset
//   i_Rx_Serial  : UART line, idle high
//   o_Move       : {right, up, down, left}, held for HOLD_CYCLES per command
//   o_Rx_Byte    : last correctly framed byte
//   o_Rx_Valid   : one-cycle pulse when o_Rx_Byte updates
//   o_Frame_Err  : one-cycle pulse on a framing (or parity) error
// -----------------------------------------------------------------------------
module uart_cmd_rx
  import frog_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int HOLD_CYCLES  = 250000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Rx_Serial,
  output logic [3:0] o_Move,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Valid,
  output logic       o_Frame_Err
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

  logic [7:0]    core_byte;
  logic          core_valid, core_err;
  cmd_t          cmd;
  logic [3:0]    move_reg;
  logic [HW-1:0] hold_reg;
  logic [7:0]    byte_reg;
  logic          valid_reg, err_reg;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .i_Clk       (i_Clk),
    .i_Rst_L     (i_Rst_L),
    .i_Rx_Serial (i_Rx_Serial),
    .o_Rx_Byte   (core_byte),
    .o_Rx_Valid  (core_valid),
    .o_Frame_Err (core_err)
  );

  assign cmd = cmd_decode(core_byte);

  // Byte, valid, error and move are all re-registered here so that they
  // change together, one edge after the stop-bit sample.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      move_reg  <= 4'b0000;
      hold_reg  <= '0;
      byte_reg  <= 8'h00;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      valid_reg <= core_valid;
      err_reg   <= core_err;
      if (core_valid) byte_reg <= core_byte;

      // Load at HOLD_CYCLES-1 and clear on the edge after reaching 0, giving
      // exactly HOLD_CYCLES cycles high. Unknown bytes leave the hold alone.
      if (core_valid && cmd.hit) begin
        move_reg <= cmd.move;
        hold_reg <= HOLD_LOAD;
      end else if (move_reg != 4'b0000) begin
        if (hold_reg == '0) move_reg <= 4'b0000;
        else                hold_reg <= hold_reg - 1'b1;
      end
    end
  end

  assign o_Move      = move_reg;
  assign o_Rx_Byte   = byte_reg;
  assign o_Rx_Valid  = valid_reg;
  assign o_Frame_Err = err_reg;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_rx
// Directed bench for uart_cmd_rx with CLKS_PER_BIT=8, HOLD_CYCLES=20.
// A negedge monitor counts pulses and measures how long each move pattern is
// held; the directed sequence compares those against hand-derived values.
// Honours UART_CMD_RX_PARITY_EN to send 8E1 frames.
// -----------------------------------------------------------------------------
module tb_uart_cmd_rx;

  localparam int CPB  = 8;
  localparam int HOLD = 20;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic [3:0] move;
  logic [7:0] rbyte;
  logic       rvalid, ferr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_cmd_rx #(
    .CLKS_PER_BIT(CPB),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .i_Clk       (clk),
    .i_Rst_L     (rst_n),
    .i_Rx_Serial (rx),
    .o_Move      (move),
    .o_Rx_Byte   (rbyte),
    .o_Rx_Valid  (rvalid),
    .o_Frame_Err (ferr)
  );

  // Monitor
  int         valid_cnt  = 0;
  int         err_cnt    = 0;
  int         mv_changes = 0;
  int         run        = 0;
  int         last_run   = 0;
  logic [3:0] last_pat   = 4'b0000;
  logic [3:0] prev_move  = 4'b0000;
  logic [7:0] byte_q[$];
  logic [3:0] mv_q[$];

  always @(negedge clk) begin
    if (rvalid) begin
      valid_cnt++;
      byte_q.push_back(rbyte);
      mv_q.push_back(move);
    end
    if (ferr) err_cnt++;
    if (move != prev_move) begin
      mv_changes++;
      if (prev_move != 4'b0000) begin
        last_run = run;
        last_pat = prev_move;
      end
      run = 1;
    end else if (move != 4'b0000) begin
      run++;
    end
    prev_move = move;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bit_out(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
`ifdef UART_CMD_RX_PARITY_EN
    bit_out((^b) ^ par_flip);
`else
    if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
    bit_out(stop_bit);
  endtask

  int v0, e0, c0;

  initial begin
    // Reset state
    #2;
    check("rst_move",  {28'd0, move},  32'h0);
    check("rst_byte",  {24'd0, rbyte}, 32'h0);
    check("rst_valid", {31'd0, rvalid}, 32'h0);
    check("rst_err",   {31'd0, ferr},  32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(10);

    // 'w' -> up, held exactly 20 cycles
    v0 = valid_cnt;
    send(8'h77, 1'b1, 1'b0);
    idle(30);
    check("w_valid_cnt", valid_cnt - v0, 1);
    check("w_byte",      {24'd0, byte_q[v0]}, 32'h77);
    check("w_move",      {28'd0, mv_q[v0]},   32'h4);
    check("w_pat",       {28'd0, last_pat},   32'h4);
    check("w_hold",      last_run, HOLD);
    check("w_move_clr",  {28'd0, move},  32'h0);
    check("w_out_byte",  {24'd0, rbyte}, 32'h77);

    // 'R' -> reset combination
    v0 = valid_cnt;
    send(8'h52, 1'b1, 1'b0);
    idle(30);
    check("R_valid_cnt", valid_cnt - v0, 1);
    check("R_move",      {28'd0, mv_q[v0]}, 32'hF);
    check("R_hold",      last_run, HOLD);
    check("R_pat",       {28'd0, last_pat}, 32'hF);

    // 'a' then 'd' back-to-back, no idle gap
    v0 = valid_cnt;
    send(8'h61, 1'b1, 1'b0);
    send(8'h64, 1'b1, 1'b0);
    idle(30);
    check("ad_valid_cnt", valid_cnt - v0, 2);
    check("ad_byte0",     {24'd0, byte_q[v0]},   32'h61);
    check("ad_move0",     {28'd0, mv_q[v0]},     32'h1);
    check("ad_byte1",     {24'd0, byte_q[v0+1]}, 32'h64);
    check("ad_move1",     {28'd0, mv_q[v0+1]},   32'h8);
    check("ad_hold",      last_run, HOLD);
    check("ad_pat",       {28'd0, last_pat}, 32'h8);

    // 'a' with stop bit 0: error only
    v0 = valid_cnt; e0 = err_cnt; c0 = mv_changes;
    send(8'h61, 1'b0, 1'b0);
    idle(30);
    check("ferr_err_cnt",   err_cnt - e0, 1);
    check("ferr_valid_cnt", valid_cnt - v0, 0);
    check("ferr_byte",      {24'd0, rbyte}, 32'h64);
    check("ferr_move_chg",  mv_changes - c0, 0);

    // 3-cycle glitch on idle line, then real 's'
    v0 = valid_cnt; e0 = err_cnt;
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(20);
    check("gl_valid_cnt", valid_cnt - v0, 0);
    check("gl_err_cnt",   err_cnt - e0, 0);
    send(8'h73, 1'b1, 1'b0);
    idle(30);
    check("s_valid_cnt", valid_cnt - v0, 1);
    check("s_byte",      {24'd0, byte_q[v0]}, 32'h73);
    check("s_move",      {28'd0, mv_q[v0]},   32'h2);
    check("s_hold",      last_run, HOLD);

    // Reset during data bit 4 of 'd' (bit 4 is 0, line low)
    bit_out(1'b0);
    bit_out(1'b0); bit_out(1'b0); bit_out(1'b1); bit_out(1'b0);
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_byte",  {24'd0, rbyte},  32'h0);
    check("mid_rst_move",  {28'd0, move},   32'h0);
    check("mid_rst_valid", {31'd0, rvalid}, 32'h0);
    check("mid_rst_err",   {31'd0, ferr},   32'h0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    v0 = valid_cnt; e0 = err_cnt;
    repeat (8) @(posedge clk);
    #1;
    idle(20);
    check("post_rst_valid", valid_cnt - v0, 0);
    check("post_rst_err",   err_cnt - e0, 0);
    send(8'h64, 1'b1, 1'b0);
    idle(30);
    check("d_valid_cnt", valid_cnt - v0, 1);
    check("d_byte",      {24'd0, byte_q[v0]}, 32'h64);
    check("d_move",      {28'd0, mv_q[v0]},   32'h8);
    check("d_hold",      last_run, HOLD);

`ifdef UART_CMD_RX_PARITY_EN
    // Odd parity on 'd': error, no valid, no move
    v0 = valid_cnt; e0 = err_cnt; c0 = mv_changes;
    send(8'h64, 1'b1, 1'b1);
    idle(30);
    check("par_err_cnt",   err_cnt - e0, 1);
    check("par_valid_cnt", valid_cnt - v0, 0);
    check("par_move_chg",  mv_changes - c0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
